tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
- Shares the slow timebase from the design's clock divider between up to N_CHAN requesters.
- The timebase arrives as a square-wave divider tap, e.g. the 2^25 output.
- Each channel has a programmable period, counted in timebase ticks. Expiries are queued per channel.
- A round-robin arbiter presents expiries one at a time on a valid/ready event port. Downstream logic such as LED blinkers, heartbeat and watchdog pokes consumes that port.

Parameters:
N_CHAN, 4, number of channels (2..16)
CHAN_W, 2, channel index width; must equal clog2(N_CHAN)
PERIOD_W, 8, period/counter width in ticks

Ports:
clk  in  1  system clock; same domain as the divider
rst_n  in  1  asynchronous, active-low reset
tick_in  in  1  divider tap level; each rising edge is one tick
cfg_we  in  1  config write strobe, one cycle
cfg_chan  in  CHAN_W  channel being written
cfg_period  in  PERIOD_W  period in ticks; 0 = disabled
cfg_en  in  1  channel enable
ev_valid  out  1  event available
ev_chan  out  CHAN_W  channel of the presented event
ev_ready  in  1  consumer accepts the event
pending  out  N_CHAN  per-channel pending flags, queued and not yet presented
overrun  out  N_CHAN  sticky per-channel lost-event flags

Behaviour:
- Reset (async assert, sync deassert by the caller):
  - Outputs: ev_valid=0, ev_chan=0, pending=0, overrun=0.
  - Internal state: all periods=0, enables=0, counters=0, tick_q=0, round-robin pointer=last channel, so channel 0 has first priority.
- Tick detect: tick = tick_in & ~tick_q, where tick_q is tick_in registered. tick_in is high for at least one clk, so each rising edge gives exactly one tick. A tick_in held high gives one tick only.
- Channel active = en & (period != 0).
- Config write to channel c (cfg_we=1):
  - Next edge: period[c]<=cfg_period, en[c]<=cfg_en, count[c]<=cfg_period-1, pending[c]<=0, overrun[c]<=0.
  - A write overrides a tick or a grant on channel c in the same cycle.
  - If c is currently held in the output register, that event is still delivered.
- Counting, on tick, per active channel not being written:
  - count!=0: count decrements.
  - count==0: count<=period-1 and the channel fires.
  - Result: the first fire is P ticks after the write, then every P ticks. P=1 fires on every tick.
- Fire handling:
  - Fire with pending[c]=0: pending[c]<=1.
  - Fire with pending[c]=1 and no grant to c in the same cycle: overrun[c]<=1, pending stays 1, the event is lost.
  - Fire in the same cycle as a grant to c: pending stays 1, no overrun.
- Output stage (registered):
  - Load condition: the stage loads when (!ev_valid | ev_ready) and pending != 0.
  - Channel selection: the first pending channel scanning from pointer+1 upward with wrap. Next edge: ev_valid<=1, ev_chan<=that channel, pending[that]<=0 (unless it fires again), pointer<=that.
  - Empty case: if the load condition holds but pending==0, ev_valid<=0.
  - Hold while stalled: while ev_valid & !ev_ready, ev_valid and ev_chan hold stable.
  - Latency: a fire at edge k gives ev_valid at edge k+1, provided the stage is free and no higher-priority channel is pending.
  - Throughput: back-to-back events with ev_ready=1 give one event per clk.
- Disable (write with en=0 or period=0): counter frozen, pending cleared, no further fires.
- Boundary cases:
  - PERIOD_W-max period counts 2^PERIOD_W-1 ticks.
  - cfg_chan >= N_CHAN writes are ignored.

Test Plan:
- Reset mid-operation: ch0 P=2 running, pull rst_n low between clk edges -> ev_valid, pending, overrun go 0 immediately, without waiting for a clk edge. After release, no events until reconfigured.
- Single channel: ch1 P=3 en=1, ticks every 8 clk, ev_ready=1 -> ev_valid pulses with ev_chan=1 one clk after ticks 3, 6, 9. Nothing after tick 1, 2, 4.
- Round-robin: ch0..ch3 all P=1, ev_ready=1 -> one tick gives ev_chan 0,1,2,3 on consecutive clks. The next tick starts at 0 again, the pointer having wrapped after 3.
- Backpressure/overrun: ch2 P=1, ev_ready=0 -> tick 1: ev_valid=1, ev_chan=2, ev_chan holds. Tick 2: pending[2]=1. Tick 3: overrun[2]=1. Raise ev_ready -> the held event, then one pending event, then ev_valid=0. A write to ch2 clears overrun[2].
- Simultaneous events: a write to ch0 in the same clk as a tick that would fire ch0 -> no fire. count=new P-1, pending[0]=0.
- Tick edge: tick_in held high for 20 clk -> exactly one tick counted. P=0 with en=1 -> never fires.

Source files
------------

// File: rtl/tick_scheduler.sv
// Shares a slow divider timebase between N_CHAN periodic requesters and
// presents their expiries one at a time, round-robin, on a valid/ready port.
module tick_scheduler #(
  parameter int N_CHAN   = 4,
  parameter int CHAN_W   = 2,
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_in,
  input  logic                cfg_we,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_en,
  output logic                ev_valid,
  output logic [CHAN_W-1:0]   ev_chan,
  input  logic                ev_ready,
  output logic [N_CHAN-1:0]   pending,
  output logic [N_CHAN-1:0]   overrun
);

  logic                tick_q_r;
  logic                tick_s;
  logic [PERIOD_W-1:0] period_r [N_CHAN];
  logic [PERIOD_W-1:0] count_r  [N_CHAN];
  logic [N_CHAN-1:0]   en_r;
  logic [N_CHAN-1:0]   pending_r;
  logic [N_CHAN-1:0]   overrun_r;
  logic [N_CHAN-1:0]   cfg_hit_s;
  logic [N_CHAN-1:0]   active_s;
  logic [N_CHAN-1:0]   fire_s;
  logic [N_CHAN-1:0]   avail_s;
  logic [N_CHAN-1:0]   grant_s;
  logic                ev_valid_r;
  logic [CHAN_W-1:0]   ev_chan_r;
  logic [CHAN_W-1:0]   ptr_r;
  logic [CHAN_W-1:0]   sel_s;
  logic [CHAN_W-1:0]   idx_s;
  logic                found_s;
  logic                load_s;

  assign tick_s   = tick_in & ~tick_q_r;
  assign load_s   = ~ev_valid_r | ev_ready;
  assign ev_valid = ev_valid_r;
  assign ev_chan  = ev_chan_r;
  assign pending  = pending_r;
  assign overrun  = overrun_r;

  // Per-channel config hit, activity and expiry decode
  always_comb begin
    cfg_hit_s = {N_CHAN{1'b0}};
    active_s  = {N_CHAN{1'b0}};
    fire_s    = {N_CHAN{1'b0}};
    for (int c = 0; c < N_CHAN; c++) begin
      cfg_hit_s[c] = cfg_we && (cfg_chan == CHAN_W'(c));
      active_s[c]  = en_r[c] && (period_r[c] != PERIOD_W'(0));
      fire_s[c]    = tick_s && active_s[c] && !cfg_hit_s[c] && (count_r[c] == PERIOD_W'(0));
    end
  end

  // Round-robin pick: first pending channel after the pointer; a channel being
  // rewritten this cycle cannot be granted
  always_comb begin
    avail_s = pending_r & ~cfg_hit_s;
    sel_s   = {CHAN_W{1'b0}};
    idx_s   = {CHAN_W{1'b0}};
    found_s = 1'b0;
    grant_s = {N_CHAN{1'b0}};
    for (int i = 1; i <= N_CHAN; i++) begin
      idx_s = CHAN_W'((int'(ptr_r) + i) % N_CHAN);
      if (!found_s && avail_s[idx_s]) begin
        found_s = 1'b1;
        sel_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    for (int c = 0; c < N_CHAN; c++) begin
      grant_s[c] = load_s && found_s && (sel_s == CHAN_W'(c));
    end
  end

  // Divider tap edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q_r <= 1'b0;
    else        tick_q_r <= tick_in;
  end

  // Channel configuration and tick counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_r <= {N_CHAN{1'b0}};
      for (int c = 0; c < N_CHAN; c++) begin
        period_r[c] <= PERIOD_W'(0);
        count_r[c]  <= PERIOD_W'(0);
      end
    end else begin
      for (int c = 0; c < N_CHAN; c++) begin
        if (cfg_hit_s[c]) begin
          period_r[c] <= cfg_period;
          en_r[c]     <= cfg_en;
          count_r[c]  <= cfg_period - PERIOD_W'(1);
        end else if (tick_s && active_s[c]) begin
          if (count_r[c] == PERIOD_W'(0)) count_r[c] <= period_r[c] - PERIOD_W'(1);
          else                            count_r[c] <= count_r[c] - PERIOD_W'(1);
        end
      end
    end
  end

  // Pending queue and sticky overrun; a fire beats a same-cycle grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {N_CHAN{1'b0}};
      overrun_r <= {N_CHAN{1'b0}};
    end else begin
      for (int c = 0; c < N_CHAN; c++) begin
        if (cfg_hit_s[c]) begin
          pending_r[c] <= 1'b0;
          overrun_r[c] <= 1'b0;
        end else if (fire_s[c]) begin
          pending_r[c] <= 1'b1;
          if (pending_r[c] && !grant_s[c]) overrun_r[c] <= 1'b1;
        end else if (grant_s[c]) begin
          pending_r[c] <= 1'b0;
        end
      end
    end
  end

  // Registered event output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid_r <= 1'b0;
      ev_chan_r  <= {CHAN_W{1'b0}};
      ptr_r      <= CHAN_W'(N_CHAN - 1);
    end else if (load_s) begin
      if (found_s) begin
        ev_valid_r <= 1'b1;
        ev_chan_r  <= sel_s;
        ptr_r      <= sel_s;
      end else begin
        ev_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed self-checking bench for tick_scheduler (N_CHAN=4, PERIOD_W=8).
module tb_tick_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_in;
  logic       cfg_we;
  logic [1:0] cfg_chan;
  logic [7:0] cfg_period;
  logic       cfg_en;
  logic       ev_valid;
  logic [1:0] ev_chan;
  logic       ev_ready;
  logic [3:0] pending;
  logic [3:0] overrun;

  int errors = 0;
  int checks = 0;

  tick_scheduler #(.N_CHAN(4), .CHAN_W(2), .PERIOD_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .cfg_we(cfg_we),
    .cfg_chan(cfg_chan), .cfg_period(cfg_period), .cfg_en(cfg_en),
    .ev_valid(ev_valid), .ev_chan(ev_chan), .ev_ready(ev_ready),
    .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0; tick_in = 1'b0; cfg_we = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] p, input logic en);
    cfg_we = 1'b1; cfg_chan = ch; cfg_period = p; cfg_en = en;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic tick_once();
    tick_in = 1'b1;
    @(posedge clk); #1;
    tick_in = 1'b0;
  endtask

  task automatic step_count(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (ev_valid) cnt++;
    end
  endtask

  task automatic test_reset();
    int c, total;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rst_ev_valid got %0b want 0", ev_valid); end
    checks++; if (ev_chan !== 2'd0) begin errors++; $display("FAIL rst_ev_chan got %0d want 0", ev_chan); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rst_pending got %b want 0000", pending); end
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL rst_overrun got %b want 0000", overrun); end
    ev_ready = 1'b0;
    cfg_write(2'd0, 8'd2, 1'b1);
    for (int t = 1; t <= 6; t++) begin
      tick_once();
      step_count(3, c);
    end
    checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL midop_valid got %0b want 1", ev_valid); end
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL midop_pending got %b want 0001", pending); end
    checks++; if (overrun !== 4'b0001) begin errors++; $display("FAIL midop_overrun got %b want 0001", overrun); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %0b want 0", ev_valid); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL async_pending got %b want 0000", pending); end
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL async_overrun got %b want 0000", overrun); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    ev_ready = 1'b1;
    total = 0;
    for (int t = 0; t < 4; t++) begin
      tick_once();
      step_count(3, c);
      total += c;
    end
    checks++; if (total !== 0) begin errors++; $display("FAIL post_rst_events got %0d want 0", total); end
  endtask

  task automatic test_single();
    int c;
    logic exp_v;
    do_reset();
    ev_ready = 1'b1;
    cfg_write(2'd1, 8'd3, 1'b1);
    for (int t = 1; t <= 9; t++) begin
      tick_once();
      @(posedge clk); #1;
      exp_v = (t % 3 == 0);
      checks++; if (ev_valid !== exp_v) begin errors++; $display("FAIL single_valid tick %0d got %0b want %0b", t, ev_valid, exp_v); end
      if (exp_v) begin
        checks++; if (ev_chan !== 2'd1) begin errors++; $display("FAIL single_chan tick %0d got %0d want 1", t, ev_chan); end
      end
      step_count(6, c);
      checks++; if (c !== 0) begin errors++; $display("FAIL single_gap tick %0d got %0d events want 0", t, c); end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    ev_ready = 1'b1;
    for (int ch = 0; ch < 4; ch++) cfg_write(2'(ch), 8'd1, 1'b1);
    for (int rep = 0; rep < 2; rep++) begin
      tick_once();
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        checks++; if (ev_valid !== 1'b1 || ev_chan !== 2'(k)) begin
          errors++; $display("FAIL rr_event rep %0d slot %0d got valid=%0b chan=%0d want valid=1 chan=%0d", rep, k, ev_valid, ev_chan, k);
        end
      end
      @(posedge clk); #1;
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rr_drain rep %0d got %0b want 0", rep, ev_valid); end
    end
  endtask

  task automatic test_backpressure();
    int c;
    do_reset();
    ev_ready = 1'b0;
    cfg_write(2'd2, 8'd1, 1'b1);
    tick_once();
    @(posedge clk); #1;
    checks++; if (ev_valid !== 1'b1 || ev_chan !== 2'd2) begin errors++; $display("FAIL bp_first got valid=%0b chan=%0d want 1/2", ev_valid, ev_chan); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL bp_pend0 got %b want 0000", pending); end
    step_count(3, c);
    checks++; if (ev_valid !== 1'b1 || ev_chan !== 2'd2) begin errors++; $display("FAIL bp_hold got valid=%0b chan=%0d want 1/2", ev_valid, ev_chan); end
    tick_once();
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL bp_pend1 got %b want 0100", pending); end
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL bp_no_ovr got %b want 0000", overrun); end
    step_count(2, c);
    tick_once();
    checks++; if (overrun !== 4'b0100) begin errors++; $display("FAIL bp_ovr got %b want 0100", overrun); end
    checks++; if (pending !== 4'b0100 || ev_chan !== 2'd2) begin errors++; $display("FAIL bp_state got pend=%b chan=%0d want 0100/2", pending, ev_chan); end
    ev_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (ev_valid !== 1'b1 || ev_chan !== 2'd2 || pending !== 4'b0000) begin
      errors++; $display("FAIL bp_queued got valid=%0b chan=%0d pend=%b want 1/2/0000", ev_valid, ev_chan, pending);
    end
    @(posedge clk); #1;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b want 0", ev_valid); end
    checks++; if (overrun !== 4'b0100) begin errors++; $display("FAIL bp_sticky got %b want 0100", overrun); end
    cfg_write(2'd2, 8'd1, 1'b1);
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL bp_clear got %b want 0000", overrun); end
  endtask

  task automatic test_simultaneous();
    int c;
    do_reset();
    ev_ready = 1'b1;
    cfg_write(2'd0, 8'd2, 1'b1);
    tick_once();
    step_count(2, c);
    tick_in = 1'b1; cfg_we = 1'b1; cfg_chan = 2'd0; cfg_period = 8'd3; cfg_en = 1'b1;
    @(posedge clk); #1;
    tick_in = 1'b0; cfg_we = 1'b0;
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL sim_pending got %b want 0000", pending); end
    step_count(3, c);
    checks++; if (c !== 0) begin errors++; $display("FAIL sim_events got %0d want 0", c); end
    for (int t = 1; t <= 3; t++) begin
      tick_once();
      checks++; if (pending[0] !== (t == 3)) begin errors++; $display("FAIL sim_count tick %0d got pend0=%0b want %0b", t, pending[0], (t == 3)); end
      if (t < 3) step_count(2, c);
    end
    @(posedge clk); #1;
    checks++; if (ev_valid !== 1'b1 || ev_chan !== 2'd0) begin errors++; $display("FAIL sim_fire got valid=%0b chan=%0d want 1/0", ev_valid, ev_chan); end
  endtask

  task automatic test_disable();
    int c;
    do_reset();
    ev_ready = 1'b0;
    cfg_write(2'd1, 8'd1, 1'b1);
    tick_once();
    step_count(2, c);
    tick_once();
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL dis_pend got %b want 0010", pending); end
    cfg_write(2'd1, 8'd1, 1'b0);
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL dis_clear got %b want 0000", pending); end
    tick_once();
    step_count(2, c);
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL dis_nofire got %b want 0000", pending); end
    checks++; if (ev_valid !== 1'b1 || ev_chan !== 2'd1) begin errors++; $display("FAIL dis_held got valid=%0b chan=%0d want 1/1", ev_valid, ev_chan); end
    ev_ready = 1'b1;
    step_count(3, c);
    checks++; if (c !== 0) begin errors++; $display("FAIL dis_after got %0d events want 0", c); end
  endtask

  task automatic test_tick_edge();
    int c1, c2;
    do_reset();
    ev_ready = 1'b1;
    cfg_write(2'd3, 8'd1, 1'b1);
    cfg_write(2'd1, 8'd0, 1'b1);
    tick_in = 1'b1;
    step_count(20, c1);
    tick_in = 1'b0;
    step_count(4, c2);
    checks++; if (c1 !== 1) begin errors++; $display("FAIL edge_high got %0d events want 1", c1); end
    checks++; if (c2 !== 0) begin errors++; $display("FAIL edge_low got %0d events want 0", c2); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL edge_p0 got %b want 0000", pending); end
    tick_once();
    @(posedge clk); #1;
    checks++; if (ev_valid !== 1'b1 || ev_chan !== 2'd3) begin errors++; $display("FAIL edge_next got valid=%0b chan=%0d want 1/3", ev_valid, ev_chan); end
    @(posedge clk); #1;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL edge_only3 got %0b want 0", ev_valid); end
  endtask

  task automatic test_max_period();
    int c, total;
    do_reset();
    ev_ready = 1'b1;
    cfg_write(2'd0, 8'd255, 1'b1);
    total = 0;
    for (int t = 1; t <= 254; t++) begin
      tick_once();
      step_count(1, c);
      total += c;
    end
    checks++; if (total !== 0) begin errors++; $display("FAIL max_early got %0d events want 0", total); end
    tick_once();
    @(posedge clk); #1;
    checks++; if (ev_valid !== 1'b1 || ev_chan !== 2'd0) begin errors++; $display("FAIL max_fire got valid=%0b chan=%0d want 1/0", ev_valid, ev_chan); end
  endtask

  initial begin
    rst_n = 1'b0; tick_in = 1'b0; cfg_we = 1'b0; cfg_chan = 2'd0;
    cfg_period = 8'd0; cfg_en = 1'b0; ev_ready = 1'b0;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_simultaneous();
    test_disable();
    test_tick_edge();
    test_max_period();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
